// File: rtl/rx_frame_sequencer.sv
// I2C receive sequencer: finds START/STOP on the synchronized bus, counts sampled bits
// into ping-pong receive buffers and runs the rx_valid/rx_ack handshake towards the host.
module rx_frame_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_SIZE    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda,
  input  logic       rx_en,
  input  logic [7:0] size,
  input  logic [7:0] burst,
  input  logic       rx_ack,
  output logic       load_b0,
  output logic       load_b1,
  output logic       bit_out,
  output logic       buff_sel,
  output logic       rx_valid,
  output logic       frame_done,
  output logic       overrun,
  output logic       abort,
  output logic       busy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] MAX_SIZE_C = CNT_W'(MAX_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WORD  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_q;
  logic                   sda_q;
  logic                   start_evt;
  logic                   stop_evt;
  logic                   sample_evt;
  logic                   sample_bit;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_nxt;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] word_cnt_nxt;
  logic [CNT_W-1:0] size_clamp;
  logic             wr_sel;
  logic             wr_sel_nxt;

  logic load_b0_nxt;
  logic load_b1_nxt;
  logic bit_out_nxt;
  logic buff_sel_nxt;
  logic rx_valid_nxt;
  logic frame_done_nxt;
  logic overrun_nxt;
  logic abort_nxt;
  logic busy_nxt;

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign size_clamp = (size > MAX_SIZE_C) ? MAX_SIZE_C : size;

  // Synchronizers and registered bus events; idle bus level is high so reset to ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync   <= '1;
      sda_sync   <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      start_evt  <= 1'b0;
      stop_evt   <= 1'b0;
      sample_evt <= 1'b0;
      sample_bit <= 1'b0;
    end else begin
      scl_sync   <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync   <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_q      <= scl_s;
      sda_q      <= sda_s;
      start_evt  <= scl_s & scl_q & sda_q & ~sda_s;
      stop_evt   <= scl_s & scl_q & ~sda_q & sda_s;
      sample_evt <= scl_s & ~scl_q;
      sample_bit <= sda_s;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      wr_sel     <= 1'b0;
      load_b0    <= 1'b0;
      load_b1    <= 1'b0;
      bit_out    <= 1'b0;
      buff_sel   <= 1'b0;
      rx_valid   <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      abort      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      word_cnt   <= word_cnt_nxt;
      wr_sel     <= wr_sel_nxt;
      load_b0    <= load_b0_nxt;
      load_b1    <= load_b1_nxt;
      bit_out    <= bit_out_nxt;
      buff_sel   <= buff_sel_nxt;
      rx_valid   <= rx_valid_nxt;
      frame_done <= frame_done_nxt;
      overrun    <= overrun_nxt;
      abort      <= abort_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    word_cnt_nxt   = word_cnt;
    wr_sel_nxt     = wr_sel;
    bit_out_nxt    = bit_out;
    buff_sel_nxt   = buff_sel;
    rx_valid_nxt   = rx_valid & ~rx_ack;
    load_b0_nxt    = 1'b0;
    load_b1_nxt    = 1'b0;
    frame_done_nxt = 1'b0;
    overrun_nxt    = 1'b0;
    abort_nxt      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_evt && rx_en) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        bit_cnt_nxt  = size_clamp;
        word_cnt_nxt = burst;
        if ((size == '0) || (burst == '0)) begin
          abort_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A bus condition mid-word truncates it; the partial word is simply not reported.
        if (stop_evt) begin
          abort_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end else if (start_evt) begin
          abort_nxt = 1'b1;
          state_nxt = ST_LOAD;
        end else if (sample_evt) begin
          load_b0_nxt = ~wr_sel;
          load_b1_nxt = wr_sel;
          bit_out_nxt = sample_bit;
          bit_cnt_nxt = bit_cnt - CNT_W'(1);
          if (bit_cnt == CNT_W'(1)) state_nxt = ST_WORD;
        end
      end
      ST_WORD: begin
        buff_sel_nxt = wr_sel;
        wr_sel_nxt   = ~wr_sel;
        rx_valid_nxt = 1'b1;
        overrun_nxt  = rx_valid & ~rx_ack;
        word_cnt_nxt = word_cnt - CNT_W'(1);
        bit_cnt_nxt  = size_clamp;
        if (word_cnt == CNT_W'(1)) begin
          frame_done_nxt = 1'b1;
          state_nxt      = ST_DRAIN;
        end else begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_DRAIN: begin
        if (stop_evt) state_nxt = ST_IDLE;
        else if (start_evt && rx_en) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Randomized bench for rx_frame_sequencer: bit-bangs I2C frames and checks strobes,
// word handshake, overrun/abort/frame_done against a frame-level reference model.
module tb_rx_frame_sequencer;

  localparam int SYNC = 2;
  localparam int MAXS = 32;
  localparam int HP   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       sda;
  logic       rx_en;
  logic [7:0] size;
  logic [7:0] burst;
  logic       rx_ack = 1'b0;
  logic       load_b0;
  logic       load_b1;
  logic       bit_out;
  logic       buff_sel;
  logic       rx_valid;
  logic       frame_done;
  logic       overrun;
  logic       abort;
  logic       busy;

  always #5 clk = ~clk;

  rx_frame_sequencer #(.SYNC_STAGES(SYNC), .MAX_SIZE(MAXS)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda), .rx_en(rx_en),
    .size(size), .burst(burst), .rx_ack(rx_ack),
    .load_b0(load_b0), .load_b1(load_b1), .bit_out(bit_out), .buff_sel(buff_sel),
    .rx_valid(rx_valid), .frame_done(frame_done), .overrun(overrun), .abort(abort),
    .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // observed activity since the last clr()
  bit st_sel[$];
  bit st_bit[$];
  int st_cyc[$];
  bit wd_sel[$];
  int wd_cyc[$];
  int n_ovr = 0, n_fd = 0, n_abt = 0, n_busy = 0, both_hi = 0;
  int fd_cyc = -1, abt_cyc = -1, st_raw = 0;
  bit rv_prev = 1'b0, auto_ack = 1'b0, man_ack = 1'b0;

  // frame-level reference state
  bit m_wr = 1'b0, m_rv = 1'b0, m_buff = 1'b0;

  always @(negedge clk) begin
    if (load_b0 && load_b1) both_hi++;
    if (load_b0 || load_b1) begin
      st_sel.push_back(load_b1);
      st_bit.push_back(bit_out);
      st_cyc.push_back(cyc);
    end
    if ((rx_valid && !rv_prev) || overrun) begin
      wd_sel.push_back(buff_sel);
      wd_cyc.push_back(cyc);
    end
    rv_prev = rx_valid;
    if (overrun) n_ovr++;
    if (frame_done) begin n_fd++; fd_cyc = cyc; end
    if (abort) begin n_abt++; abt_cyc = cyc; end
    if (busy) n_busy++;
    rx_ack = (auto_ack && rx_valid) || man_ack;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    @(posedge clk);
    st_sel.delete(); st_bit.delete(); st_cyc.delete();
    wd_sel.delete(); wd_cyc.delete();
    n_ovr = 0; n_fd = 0; n_abt = 0; n_busy = 0; both_hi = 0;
    fd_cyc = -1; abt_cyc = -1;
    @(negedge clk);
  endtask

  task automatic bus_start();
    sda = 1'b1; wait_cyc(HP);
    scl = 1'b1; wait_cyc(HP);
    st_raw = cyc;
    sda = 1'b0; wait_cyc(HP);
    scl = 1'b0; wait_cyc(HP);
  endtask

  task automatic bus_bit(input bit b, output int rc);
    sda = b; wait_cyc(HP);
    scl = 1'b1; rc = cyc; wait_cyc(HP);
    scl = 1'b0; wait_cyc(1);
  endtask

  task automatic bus_stop();
    sda = 1'b0; wait_cyc(HP);
    scl = 1'b1; wait_cyc(HP);
    sda = 1'b1; wait_cyc(HP);
  endtask

  task automatic run_frame(input int sz, input int bu, input bit ack, input int extra,
                           input bit fixed, input logic [31:0] d0, input logic [31:0] d1);
    int nb, exp_ovr, rise0, rc, bad, base;
    logic [31:0] data[$];
    bit exp_sel[$];
    logic [31:0] d, v;
    nb = (sz > MAXS) ? MAXS : sz;
    size = 8'(sz); burst = 8'(bu); auto_ack = ack;
    if (ack) begin wait_cyc(3); m_rv = 1'b0; end
    exp_ovr = 0;
    for (int w = 0; w < bu; w++) begin
      d = fixed ? ((w == 0) ? d0 : d1) : $urandom;
      if (nb < 32) d = d & ((32'd1 << nb) - 32'd1);
      data.push_back(d);
      exp_sel.push_back(m_wr);
      if (m_rv && !ack) exp_ovr++;
      m_buff = m_wr;
      m_wr   = ~m_wr;
      m_rv   = !ack;
    end
    clr();
    bus_start();
    rise0 = -1;
    for (int w = 0; w < bu; w++) begin
      d = data[w];
      for (int i = 0; i < nb; i++) begin
        bus_bit(d[nb-1-i], rc);
        if (rise0 < 0) rise0 = rc;
      end
    end
    for (int i = 0; i < extra; i++) bus_bit(1'($urandom), rc);
    bus_stop();
    wait_cyc(8);
    chk("strobe_count", st_sel.size(), nb * bu);
    chk("strobe_excl", both_hi, 0);
    if (st_cyc.size() > 0) chk("strobe_latency", st_cyc[0] - rise0, SYNC + 2);
    if (st_sel.size() == nb * bu) begin
      for (int w = 0; w < bu; w++) begin
        v = '0; bad = 0; base = w * nb;
        for (int i = 0; i < nb; i++) begin
          v = {v[30:0], st_bit[base+i]};
          if (st_sel[base+i] != exp_sel[w]) bad++;
        end
        chk("word_data", v, data[w]);
        chk("word_buffer", bad, 0);
      end
    end
    chk("word_events", wd_sel.size(), bu);
    for (int k = 0; k < wd_sel.size() && k < bu; k++)
      chk("evt_buff_sel", 32'(wd_sel[k]), 32'(exp_sel[k]));
    chk("overrun_count", n_ovr, exp_ovr);
    chk("frame_done_count", n_fd, 1);
    chk("abort_count", n_abt, 0);
    if (st_cyc.size() > 0 && wd_cyc.size() > 0) begin
      chk("valid_after_strobe", wd_cyc[$] - st_cyc[$], 1);
      chk("frame_done_cycle", fd_cyc, wd_cyc[$]);
    end
    chk("rx_valid_end", 32'(rx_valid), 32'(m_rv));
    chk("buff_sel_end", 32'(buff_sel), 32'(m_buff));
    chk("busy_end", 32'(busy), 0);
  endtask

  task automatic run_abort(input int sz, input int bu);
    int rc;
    size = 8'(sz); burst = 8'(bu);
    clr();
    bus_start();
    for (int i = 0; i < 3; i++) bus_bit(1'($urandom), rc);
    bus_stop();
    wait_cyc(6);
    chk("cfg_abort_count", n_abt, 1);
    chk("cfg_abort_latency", abt_cyc - st_raw, SYNC + 3);
    chk("cfg_abort_strobes", st_sel.size(), 0);
    chk("cfg_abort_frame_done", n_fd, 0);
    chk("cfg_abort_busy", 32'(busy), 0);
  endtask

  initial begin
    int rc;
    reset = 1'b1; scl = 1'b1; sda = 1'b1; rx_en = 1'b1; size = 8'd8; burst = 8'd1;
    wait_cyc(3);
    chk("reset_outputs", 32'({load_b0, load_b1, bit_out, buff_sel, rx_valid,
                              frame_done, overrun, abort, busy}), 0);
    reset = 1'b0;
    wait_cyc(2);

    run_frame(8, 2, 1'b1, 0, 1'b1, 32'hA5, 32'h3C);
    run_frame(8, 3, 1'b0, 0, 1'b0, '0, '0);
    man_ack = 1'b1; wait_cyc(2); man_ack = 1'b0; m_rv = 1'b0; wait_cyc(1);
    chk("ack_clears_valid", 32'(rx_valid), 0);
    run_frame(40, 1, 1'b1, 8, 1'b0, '0, '0);

    run_abort(0, 2);
    run_abort(8, 0);

    // STOP raised during the high phase of the 5th bit of an 8-bit word
    size = 8'd8; burst = 8'd1; auto_ack = 1'b1;
    clr();
    bus_start();
    for (int i = 0; i < 4; i++) bus_bit(1'($urandom), rc);
    sda = 1'b0; wait_cyc(HP);
    scl = 1'b1; wait_cyc(HP);
    sda = 1'b1; wait_cyc(HP + 6);
    chk("trunc_strobes", st_sel.size(), 5);
    chk("trunc_abort", n_abt, 1);
    chk("trunc_frame_done", n_fd, 0);
    chk("trunc_rx_valid", 32'(rx_valid), 0);
    chk("trunc_busy", 32'(busy), 0);
    if (st_sel.size() > 0) chk("trunc_buffer", 32'(st_sel[0]), 32'(m_wr));
    run_frame(4, 1, 1'b1, 0, 1'b0, '0, '0);

    for (int r = 0; r < 6; r++)
      run_frame($urandom_range(1, 12), $urandom_range(1, 3), 1'($urandom_range(0, 1)), 0,
                1'b0, '0, '0);

    // leave a word pending, then reset during the 3rd bit of the next frame
    run_frame(6, 1, 1'b0, 0, 1'b0, '0, '0);
    size = 8'd8; burst = 8'd1;
    clr();
    bus_start();
    for (int i = 0; i < 2; i++) bus_bit(1'($urandom), rc);
    sda = 1'b1; wait_cyc(HP);
    scl = 1'b1; wait_cyc(2);
    reset = 1'b1; wait_cyc(1);
    chk("midframe_reset_outputs", 32'({load_b0, load_b1, bit_out, buff_sel, rx_valid,
                                       frame_done, overrun, abort, busy}), 0);
    reset = 1'b0;
    m_wr = 1'b0; m_rv = 1'b0; m_buff = 1'b0;
    wait_cyc(HP + 4);
    chk("midframe_reset_no_abort", n_abt, 0);

    rx_en = 1'b0;
    clr();
    bus_start();
    for (int i = 0; i < 3; i++) bus_bit(1'($urandom), rc);
    bus_stop();
    wait_cyc(6);
    chk("rx_en_low_strobes", st_sel.size(), 0);
    chk("rx_en_low_busy", n_busy, 0);
    rx_en = 1'b1;
    run_frame(5, 2, 1'b1, 0, 1'b0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
